// File: rtl/fft_pkg.sv
// Shared types and constants for the framer and the 8-point FFT.
// Complex sample layout, bank and launch states, frame slicing helpers.
package fft_pkg;

  localparam int DW  = 8;
  localparam int NPT = 8;
  localparam int CW  = 2 * DW;
  localparam int FW  = NPT * CW;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } launch_state_e;

  function automatic logic [DW-1:0] re_of(
    input logic [FW-1:0] f,
    input int            k
  );
    return f[k*CW+DW +: DW];
  endfunction

  function automatic logic [DW-1:0] im_of(
    input logic [FW-1:0] f,
    input int            k
  );
    return f[k*CW +: DW];
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of NPT complex samples: indexed write, parallel read.
// Ports: clk, rst (sync, active-low clear), we, widx, wdata, rdata.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    widx,
  input  logic [CW-1:0] wdata,
  output logic [FW-1:0] rdata
);

  logic [FW-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[widx*CW +: CW] <= wdata;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-frame ping-pong buffer feeding the 8-point pipelined FFT.
// Ports: sample handshake in, parallel frame + start/done out, busy, frame_cnt.
module fft_input_framer
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          fft_done,
  output logic          fft_start,
  output logic [DW-1:0] x_real0,
  output logic [DW-1:0] x_real1,
  output logic [DW-1:0] x_real2,
  output logic [DW-1:0] x_real3,
  output logic [DW-1:0] x_real4,
  output logic [DW-1:0] x_real5,
  output logic [DW-1:0] x_real6,
  output logic [DW-1:0] x_real7,
  output logic [DW-1:0] x_imag0,
  output logic [DW-1:0] x_imag1,
  output logic [DW-1:0] x_imag2,
  output logic [DW-1:0] x_imag3,
  output logic [DW-1:0] x_imag4,
  output logic [DW-1:0] x_imag5,
  output logic [DW-1:0] x_imag6,
  output logic [DW-1:0] x_imag7,
  output logic          fft_busy,
  output logic [15:0]   frame_cnt
);

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  launch_state_e lst_q;

  logic [2:0]  wr_idx_q, wr_idx_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        in_ready_q, in_ready_d;
  logic        fft_start_q, fft_busy_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        accept, last, done_ev, launch;

  cplx_t       wdata;
  logic [FW-1:0] rd0, rd1, rdv;

  assign wdata = cplx_t'{re: in_real, im: in_imag};

  always_comb begin
    accept  = in_valid & in_ready_q;
    last    = accept & (wr_idx_q == 3'(NPT-1));
    done_ev = (lst_q == BUSY) & fft_done;
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    // fill and free always hit different banks
    if (last)    bank_d[wr_bank_q] = FULL;
    if (done_ev) bank_d[rd_bank_q] = EMPTY;
    wr_idx_d  = accept ? wr_idx_q + 3'd1 : wr_idx_q;
    wr_bank_d = wr_bank_q ^ last;
    rd_bank_d = rd_bank_q ^ done_ev;
    in_ready_d = (bank_d[wr_bank_d] == EMPTY);
    // look ahead so a frame filled at this edge starts next cycle
    launch = (lst_q == IDLE) &
             (bank_d[rd_bank_q] == FULL);
    frame_cnt_d = frame_cnt_q + {15'd0, launch};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      in_ready_q  <= in_ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lst_q       <= IDLE;
      fft_start_q <= 1'b0;
      fft_busy_q  <= 1'b0;
    end else begin
      fft_start_q <= 1'b0;
      unique case (lst_q)
        IDLE: begin
          if (launch) begin
            lst_q       <= START;
            fft_start_q <= 1'b1;
            fft_busy_q  <= 1'b1;
          end
        end
        START: lst_q <= BUSY;
        BUSY: begin
          if (fft_done) begin
            lst_q      <= IDLE;
            fft_busy_q <= 1'b0;
          end
        end
        default: lst_q <= IDLE;
      endcase
    end
  end

  fft_frame_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept & ~wr_bank_q),
    .widx  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd0)
  );

  fft_frame_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept & wr_bank_q),
    .widx  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd1)
  );

  assign rdv = rd_bank_q ? rd1 : rd0;

  assign x_real0 = re_of(rdv, 0);
  assign x_real1 = re_of(rdv, 1);
  assign x_real2 = re_of(rdv, 2);
  assign x_real3 = re_of(rdv, 3);
  assign x_real4 = re_of(rdv, 4);
  assign x_real5 = re_of(rdv, 5);
  assign x_real6 = re_of(rdv, 6);
  assign x_real7 = re_of(rdv, 7);
  assign x_imag0 = im_of(rdv, 0);
  assign x_imag1 = im_of(rdv, 1);
  assign x_imag2 = im_of(rdv, 2);
  assign x_imag3 = im_of(rdv, 3);
  assign x_imag4 = im_of(rdv, 4);
  assign x_imag5 = im_of(rdv, 5);
  assign x_imag6 = im_of(rdv, 6);
  assign x_imag7 = im_of(rdv, 7);

  assign in_ready  = in_ready_q;
  assign fft_start = fft_start_q;
  assign fft_busy  = fft_busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: directed frames, scoreboard of launched frames.
// Stimulus pushes expected frames; a negedge monitor checks each fft_start.
module tb_fft_input_framer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_real;
  logic [7:0] in_imag;
  logic       fft_done;
  logic       fft_start;
  logic [7:0] x_real0, x_real1, x_real2, x_real3;
  logic [7:0] x_real4, x_real5, x_real6, x_real7;
  logic [7:0] x_imag0, x_imag1, x_imag2, x_imag3;
  logic [7:0] x_imag4, x_imag5, x_imag6, x_imag7;
  logic       fft_busy;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [63:0] re;
    logic [63:0] im;
    logic [15:0] cnt;
  } frm_t;

  frm_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   auto_done = 0;

  logic [63:0] xr, xi;
  assign xr = {x_real7, x_real6, x_real5, x_real4,
               x_real3, x_real2, x_real1, x_real0};
  assign xi = {x_imag7, x_imag6, x_imag5, x_imag4,
               x_imag3, x_imag2, x_imag1, x_imag0};

  fft_input_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .fft_done  (fft_done),
    .fft_start (fft_start),
    .x_real0   (x_real0),
    .x_real1   (x_real1),
    .x_real2   (x_real2),
    .x_real3   (x_real3),
    .x_real4   (x_real4),
    .x_real5   (x_real5),
    .x_real6   (x_real6),
    .x_real7   (x_real7),
    .x_imag0   (x_imag0),
    .x_imag1   (x_imag1),
    .x_imag2   (x_imag2),
    .x_imag3   (x_imag3),
    .x_imag4   (x_imag4),
    .x_imag5   (x_imag5),
    .x_imag6   (x_imag6),
    .x_imag7   (x_imag7),
    .fft_busy  (fft_busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] v0,
                                        input logic [7:0] st);
    logic [63:0] f;
    logic [7:0]  v;
    v = v0;
    for (int k = 0; k < 8; k++) begin
      f[8*k +: 8] = v;
      v = v + st;
    end
    return f;
  endfunction

  task automatic push_frame(input logic [7:0] r0, rst_p,
                            input logic [7:0] i0, ist,
                            input logic [15:0] cnt);
    frm_t f;
    f.re  = pack8(r0, rst_p);
    f.im  = pack8(i0, ist);
    f.cnt = cnt;
    sbq.push_back(f);
  endtask

  // entered and left on a negedge; w = stall cycles
  task automatic send(input logic [7:0] r, im,
                      input bit gap, output int w);
    w = 0;
    if (gap && $urandom_range(1) == 1) @(negedge clk);
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = im;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) fail_now("send_timeout");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] r0, rst_p,
                            input logic [7:0] i0, ist,
                            input bit gap, output int wt);
    logic [7:0] r, i;
    int w;
    r  = r0;
    i  = i0;
    wt = 0;
    for (int k = 0; k < 8; k++) begin
      send(r, i, gap, w);
      wt += w;
      r = r + rst_p;
      i = i + ist;
    end
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && fft_start) begin
      if (sbq.size() == 0) begin
        fail_now("unexpected_start");
      end else begin
        frm_t e;
        e = sbq.pop_front();
        chk("mon_x_real", xr, e.re);
        chk("mon_x_imag", xi, e.im);
        chk("mon_frame_cnt", {48'd0, frame_cnt}, {48'd0, e.cnt});
        chk("mon_busy", {63'd0, fft_busy}, 64'd1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_done && fft_start) begin
        repeat (5) @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w3;
    int t;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    fft_done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_start", {63'd0, fft_start}, 64'd0);
    chk("rst_busy", {63'd0, fft_busy}, 64'd0);
    chk("rst_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("rst_x", xr | xi, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // test 1: back-to-back frame 1..8
    push_frame(8'd1, 8'd1, 8'd0, 8'd0, 16'd1);
    send_frame(8'd1, 8'd1, 8'd0, 8'd0, 1'b0, w);
    chk("t1_stalls", w, 0);
    chk("t1_start_lat", {63'd0, fft_start}, 64'd1);
    @(negedge clk);
    chk("t1_start_1cyc", {63'd0, fft_start}, 64'd0);
    chk("t1_busy", {63'd0, fft_busy}, 64'd1);

    // test 2: long FFT, backpressure, hold
    repeat (28) @(negedge clk);
    push_frame(8'd9, 8'd1, 8'hFF, 8'hFF, 16'd2);
    send_frame(8'd9, 8'd1, 8'hFF, 8'hFF, 1'b0, w);
    chk("t2_nostall", w, 0);
    chk("t2_ready_low", {63'd0, in_ready}, 64'd0);
    chk("t2_no_start", {63'd0, fft_start}, 64'd0);
    chk("t2_hold_a", xr, pack8(8'd1, 8'd1));
    push_frame(8'd17, 8'd1, 8'h7F, 8'd0, 16'd3);
    fork
      send_frame(8'd17, 8'd1, 8'h7F, 8'd0, 1'b0, w3);
      begin
        repeat (10) @(negedge clk);
        chk("t2_hold_b", xr, pack8(8'd1, 8'd1));
        chk("t2_still_blocked", {63'd0, in_ready}, 64'd0);
        pulse_done();
        chk("t2_ready_after", {63'd0, in_ready}, 64'd1);
        chk("t2_busy_drop", {63'd0, fft_busy}, 64'd0);
        chk("t2_idle_gap", {63'd0, fft_start}, 64'd0);
        @(negedge clk);
        chk("t2_start_2cyc", {63'd0, fft_start}, 64'd1);
      end
    join
    repeat (3) @(negedge clk);
    pulse_done();
    @(negedge clk);
    chk("t2_f3_start", {63'd0, fft_start}, 64'd1);
    repeat (3) @(negedge clk);
    pulse_done();

    // test 5: done in IDLE and in START ignored
    chk("t5_idle_busy", {63'd0, fft_busy}, 64'd0);
    pulse_done();
    chk("t5_idle_done_busy", {63'd0, fft_busy}, 64'd0);
    chk("t5_idle_done_cnt", {48'd0, frame_cnt}, 64'd3);
    push_frame(8'h30, 8'd1, 8'hF0, 8'd1, 16'd4);
    send_frame(8'h30, 8'd1, 8'hF0, 8'd1, 1'b0, w);
    chk("t5_start", {63'd0, fft_start}, 64'd1);
    pulse_done();
    chk("t5_start_done_busy", {63'd0, fft_busy}, 64'd1);
    repeat (4) @(negedge clk);
    chk("t5_still_busy", {63'd0, fft_busy}, 64'd1);
    chk("t5_hold", xr, pack8(8'h30, 8'd1));
    pulse_done();
    chk("t5_real_done", {63'd0, fft_busy}, 64'd0);

    // test 3: gapped input, auto done
    auto_done = 1'b1;
    for (int j = 0; j < 3; j++) begin
      push_frame(8'h50 + 8'(8*j), 8'd1,
                 8'hC0 + 8'(8*j), 8'd3, 16'(5 + j));
    end
    for (int j = 0; j < 3; j++) begin
      send_frame(8'h50 + 8'(8*j), 8'd1,
                 8'hC0 + 8'(8*j), 8'd3, 1'b1, w);
    end
    t = 0;
    while ((sbq.size() != 0 || fft_busy || fft_done) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("t3_drain");
    repeat (2) @(negedge clk);
    auto_done = 1'b0;
    chk("t3_cnt", {48'd0, frame_cnt}, 64'd7);
    chk("t3_sb_empty", sbq.size(), 0);

    // test 4: reset mid-fill discards partial frame
    for (int k = 0; k < 5; k++) send(8'h11 + 8'(k), 8'h22, 1'b0, w);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_rst_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("t4_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("t4_rst_x", xr | xi, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    pulse_done();
    chk("t4_late_done", {63'd0, fft_busy}, 64'd0);
    push_frame(8'hA0, 8'd1, 8'h5A, 8'd1, 16'd1);
    send_frame(8'hA0, 8'd1, 8'h5A, 8'd1, 1'b0, w);
    chk("t4_start", {63'd0, fft_start}, 64'd1);
    repeat (3) @(negedge clk);
    pulse_done();

    // test 6: frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("t6_preload", {48'd0, frame_cnt}, 64'hFFFF);
    push_frame(8'hB0, 8'd1, 8'h00, 8'h11, 16'd0);
    send_frame(8'hB0, 8'd1, 8'h00, 8'h11, 1'b0, w);
    @(negedge clk);
    chk("t6_wrap", {48'd0, frame_cnt}, 64'd0);
    repeat (3) @(negedge clk);
    pulse_done();
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
